// File: rtl/cpu_sequencer_pkg.sv
// cpu_defs: shared widths, opcodes and state codes for the 2-bit computer sequencer
package cpu_defs;
  localparam int IW = 4;
  localparam int AW = 2;
  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, EXEC = 2'b10, HALT = 2'b11} state_t;
endpackage

// File: rtl/cpu_sequencer_pc_counter.sv
// pc_counter: program counter register with async clear; load beats increment
module pc_counter #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else        q <= load ? d : inc ? q + 1'b1 : q;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute control for the 2-bit computer with run, single-step and halt
module cpu_sequencer
  import cpu_defs::*;
(
  input  logic          CLK,
  input  logic          Reset_BAR,
  input  logic          run,
  input  logic          step,
  input  logic [IW-1:0] instr,
  input  logic          mem_ready,
  output logic          mem_req,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] ir,
  output logic          a_load,
  output logic          a_src,
  output logic          halted,
  output logic          busy,
  output logic [1:0]    state
);
  state_t        state_q, state_d;
  logic [IW-1:0] ir_d;
  logic          step_mode, step_mode_d;
  logic [1:0]    op;
  assign op = ir[3:2];
  always_ff @(posedge CLK or negedge Reset_BAR)
    if (!Reset_BAR) begin
      state_q   <= IDLE;
      ir        <= '0;
      step_mode <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir        <= ir_d;
      step_mode <= step_mode_d;
    end
  always_comb begin
    state_d     = state_q;
    ir_d        = ir;
    step_mode_d = step_mode;
    unique case (state_q)
      IDLE: if (run || step) begin
        state_d     = FETCH;
        step_mode_d = !run;
      end
      FETCH: if (mem_ready) begin
        state_d = EXEC;
        ir_d    = instr;
      end
      EXEC:    state_d = op == OP_HLT ? HALT : (step_mode || !run) ? IDLE : FETCH;
      default: state_d = HALT;
    endcase
  end
  pc_counter #(.AW(AW)) u_pc (
    .clk  (CLK),
    .rst_n(Reset_BAR),
    .inc  (state_q == EXEC && (op == OP_LDI || op == OP_ADD)),
    .load (state_q == EXEC && op == OP_JMP),
    .d    (ir[AW-1:0]),
    .q    (pc)
  );
  assign mem_req = state_q == FETCH;
  assign a_load  = state_q == EXEC && (op == OP_LDI || op == OP_ADD);
  assign a_src   = state_q == EXEC && op == OP_ADD;
  assign halted  = state_q == HALT;
  assign busy    = state_q == FETCH || state_q == EXEC;
  assign state   = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of fetch/execute, step, stall, wrap, halt and reset
module tb_cpu_sequencer;
  logic       CLK = 1'b0;
  logic       Reset_BAR = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] instr;
  logic       mem_req, a_load, a_src, halted, busy;
  logic [1:0] pc, state;
  logic [3:0] ir;
  logic [3:0] prog [4];
  int checks = 0;
  int errors = 0;
  always #5 CLK = ~CLK;
  assign instr = prog[pc];
  cpu_sequencer dut (
    .CLK(CLK), .Reset_BAR(Reset_BAR), .run(run), .step(step), .instr(instr),
    .mem_ready(mem_ready), .mem_req(mem_req), .pc(pc), .ir(ir), .a_load(a_load),
    .a_src(a_src), .halted(halted), .busy(busy), .state(state)
  );
  logic [8:0] obs;
  assign obs = {state, pc, a_load, a_src, mem_req, halted, busy};
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    Reset_BAR = 1'b0;
    tick();
    Reset_BAR = 1'b1;
  endtask
  task automatic test_reset();
    run = 1'b1; mem_ready = 1'b1; step = 1'b1;
    Reset_BAR = 1'b0;
    #2;
    checks++;
    if (obs !== 9'b0 || ir !== 4'h0) begin
      errors++; $display("FAIL reset_outputs: got %b ir=%h, want 000000000 ir=0", obs, ir);
    end
    tick();
    checks++;
    if (obs !== 9'b0) begin
      errors++; $display("FAIL reset_hold: got %b, want 000000000", obs);
    end
    run = 1'b0; step = 1'b0; mem_ready = 1'b0;
  endtask
  task automatic test_freerun();
    logic [8:0] t [8];
    t[0] = 9'b01_00_0_0_1_0_1; t[1] = 9'b10_00_1_0_0_0_1;
    t[2] = 9'b01_01_0_0_1_0_1; t[3] = 9'b10_01_1_1_0_0_1;
    t[4] = 9'b01_10_0_0_1_0_1; t[5] = 9'b10_10_0_0_0_0_1;
    t[6] = 9'b01_00_0_0_1_0_1; t[7] = 9'b10_00_1_0_0_0_1;
    prog[0] = 4'b0010; prog[1] = 4'b0101; prog[2] = 4'b1000; prog[3] = 4'b1100;
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== t[i]) begin
        errors++; $display("FAIL freerun_cycle%0d: got %b, want %b", i + 1, obs, t[i]);
      end
    end
    run = 1'b0;
  endtask
  task automatic test_halt();
    prog[0] = 4'b0001; prog[1] = 4'b1100; prog[2] = 4'b0000; prog[3] = 4'b0000;
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (obs !== 9'b11_01_0_0_0_1_0 || ir !== 4'b1100) begin
      errors++; $display("FAIL halt_enter: got %b ir=%b, want 110100010 ir=1100", obs, ir);
    end
    for (int i = 0; i < 4; i++) begin
      run = i[0]; step = ~i[0]; mem_ready = i[1];
      tick();
      checks++;
      if (obs !== 9'b11_01_0_0_0_1_0) begin
        errors++; $display("FAIL halt_sticky%0d: got %b, want 110100010", i, obs);
      end
    end
    step = 1'b0;
    #3 Reset_BAR = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0 || ir !== 4'h0) begin
      errors++; $display("FAIL halt_async_reset: got %b ir=%h, want 000000000 ir=0", obs, ir);
    end
    tick();
    Reset_BAR = 1'b1; run = 1'b0;
  endtask
  task automatic test_step();
    prog[0] = 4'b0000; prog[1] = 4'b0000; prog[2] = 4'b0000; prog[3] = 4'b0000;
    do_reset();
    mem_ready = 1'b1; step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (obs !== 9'b01_00_0_0_1_0_1) begin
      errors++; $display("FAIL step_fetch: got %b, want 010000101", obs);
    end
    tick();
    checks++;
    if (obs !== 9'b10_00_1_0_0_0_1) begin
      errors++; $display("FAIL step_exec: got %b, want 100010001", obs);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (obs !== 9'b00_01_0_0_0_0_0) begin
      errors++; $display("FAIL step_idle: got %b, want 000100000", obs);
    end
    tick();
    checks++;
    if (obs !== 9'b00_01_0_0_0_0_0) begin
      errors++; $display("FAIL step_not_queued: got %b, want 000100000", obs);
    end
  endtask
  task automatic test_stall();
    prog[0] = 4'b0110; prog[1] = 4'b0000; prog[2] = 4'b0000; prog[3] = 4'b0000;
    do_reset();
    run = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) mem_ready = 1'b1;
      checks++;
      if (obs !== 9'b01_00_0_0_1_0_1 || ir !== 4'h0) begin
        errors++; $display("FAIL stall_cycle%0d: got %b ir=%b, want 010000101 ir=0000", i + 1, obs, ir);
      end
    end
    tick();
    checks++;
    if (obs !== 9'b10_00_1_1_0_0_1 || ir !== 4'b0110) begin
      errors++; $display("FAIL stall_capture: got %b ir=%b, want 100011001 ir=0110", obs, ir);
    end
    run = 1'b0;
  endtask
  task automatic test_wrap();
    logic [8:0] e;
    logic [1:0] p;
    prog[0] = 4'b0000; prog[1] = 4'b0001; prog[2] = 4'b0010; prog[3] = 4'b0011;
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      p = (i % 2 == 0) ? 2'((i / 2 - 1) % 4) : 2'(((i - 1) / 2) % 4);
      e = (i % 2 == 0) ? {2'b10, p, 5'b1_0_0_0_1} : {2'b01, p, 5'b0_0_1_0_1};
      checks++;
      if (obs !== e || (i % 2 == 0 && ir !== {2'b00, p})) begin
        errors++; $display("FAIL wrap_cycle%0d: got %b ir=%b, want %b ir=00%b", i, obs, ir, e, p);
      end
    end
    run = 1'b0;
  endtask
  task automatic test_reset_mid_fetch();
    prog[0] = 4'b0111; prog[1] = 4'b0111; prog[2] = 4'b0111; prog[3] = 4'b0111;
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    tick();
    #2 Reset_BAR = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || state !== 2'b00) begin
      errors++; $display("FAIL abort_async: got req=%b busy=%b state=%b, want 0 0 00", mem_req, busy, state);
    end
    tick();
    checks++;
    if (ir !== 4'h0 || state !== 2'b00) begin
      errors++; $display("FAIL abort_ir: got ir=%b state=%b, want 0000 00", ir, state);
    end
    Reset_BAR = 1'b1; step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    tick();
    checks++;
    if (obs !== 9'b01_01_0_0_1_0_1) begin
      errors++; $display("FAIL run_priority: got %b, want 010100101", obs);
    end
    run = 1'b0;
    tick();
    checks++;
    if (obs !== 9'b10_01_1_1_0_0_1) begin
      errors++; $display("FAIL run_drop_exec: got %b, want 100111001", obs);
    end
    tick();
    checks++;
    if (obs !== 9'b00_10_0_0_0_0_0) begin
      errors++; $display("FAIL run_drop_idle: got %b, want 001000000", obs);
    end
  endtask
  initial begin
    prog[0] = 4'h0; prog[1] = 4'h0; prog[2] = 4'h0; prog[3] = 4'h0;
    test_reset();
    test_freerun();
    test_halt();
    test_step();
    test_stall();
    test_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
